// File: rtl/pc_gen_pkg.sv
// Shared constants for the program-counter generator: state encodings,
// target-select codes and default parameter values.
package pc_gen_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES_DEFAULT  = 4;
    localparam int          BOOT_CYCLES_DEFAULT  = 2;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Ordered lowest to highest priority
    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_PREDIR = 3'd1;
    localparam logic [2:0] SEL_REDIR  = 3'd2;
    localparam logic [2:0] SEL_PTRAP  = 3'd3;
    localparam logic [2:0] SEL_TRAP   = 3'd4;

endpackage

// File: rtl/pc_redirect_buffer.sv
// Single-entry holding register for a redirect or trap target that arrives
// while the PC cannot advance; a trap is never displaced by a redirect.
module pc_redirect_buffer
    import pc_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            capture_en_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    output logic            pend_valid_o,
    output logic            pend_is_trap_o,
    output logic [XLEN-1:0] pend_target_o
);

    logic            valid_q, valid_d;
    logic            is_trap_q, is_trap_d;
    logic [XLEN-1:0] target_q, target_d;

    always_comb begin
        valid_d   = valid_q;
        is_trap_d = is_trap_q;
        target_d  = target_q;
        if (clear_i) begin
            valid_d   = 1'b0;
            is_trap_d = 1'b0;
        end else if (capture_en_i) begin
            if (trap_valid_i) begin
                valid_d   = 1'b1;
                is_trap_d = 1'b1;
                target_d  = trap_pc_i;
            end else if (redirect_valid_i && !(valid_q && is_trap_q)) begin
                valid_d   = 1'b1;
                is_trap_d = 1'b0;
                target_d  = redirect_pc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            is_trap_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            is_trap_q <= is_trap_d;
        end
        // Target is qualified by valid_q, so it needs no reset
        target_q <= target_d;
    end

    assign pend_valid_o   = valid_q;
    assign pend_is_trap_o = is_trap_q;
    assign pend_target_o  = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, prioritised
// trap/redirect/sequential target selection and a one-deep pending buffer.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT,
    parameter int              BOOT_CYCLES  = BOOT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect_pending
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [3:0]      BOOT_LAST  = 4'(BOOT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      boot_cnt_q, boot_cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;

    logic [XLEN-1:0] redir_al, trap_al, target;
    logic [2:0]      sel;
    logic            advance;
    logic            pend_valid, pend_is_trap;
    logic [XLEN-1:0] pend_target;

    assign redir_al = redirect_pc & ALIGN_MASK;
    assign trap_al  = trap_pc & ALIGN_MASK;

    // A halt request in RUN freezes the PC on that edge, so it blocks advance
    assign advance = (state_q == ST_RUN) && pc_en && !halt_req;

    pc_redirect_buffer #(.XLEN(XLEN)) u_buf (
        .clk              (clk),
        .rst              (rst),
        .clear_i          (advance),
        .capture_en_i     (!advance),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redir_al),
        .trap_valid_i     (trap_valid),
        .trap_pc_i        (trap_al),
        .pend_valid_o     (pend_valid),
        .pend_is_trap_o   (pend_is_trap),
        .pend_target_o    (pend_target)
    );

    always_comb begin
        if (trap_valid)                     sel = SEL_TRAP;
        else if (pend_valid && pend_is_trap) sel = SEL_PTRAP;
        else if (redirect_valid)            sel = SEL_REDIR;
        else if (pend_valid)                sel = SEL_PREDIR;
        else                                sel = SEL_SEQ;

        case (sel)
            SEL_TRAP:              target = trap_al;
            SEL_PTRAP, SEL_PREDIR: target = pend_target;
            SEL_REDIR:             target = redir_al;
            default:               target = pc_q + XLEN'(INSTR_BYTES);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req)   state_d = ST_HALT;
                else if (pc_en) pc_d    = target;
            end
            ST_HALT: begin
                if (resume_req) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = pc_valid_q;
    assign redirect_pending = pend_valid;

endmodule
